// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM stage: control bundle, default payload layout and
// the (main_v, skid_v) occupancy encoding used by the skid buffer.
package ex_mem_pkg;

    typedef struct packed {
        logic MemtoReg;
        logic RegWr;
        logic MemWr;
    } ex_mem_ctrl_t;

    localparam int CTRL_W      = $bits(ex_mem_ctrl_t);
    localparam int DATA_W_DEF  = 32;
    localparam int RADDR_W_DEF = 5;

    // Payload at default widths; the top packs the same field order for any width.
    typedef struct packed {
        logic [DATA_W_DEF-1:0]  result;
        logic [DATA_W_DEF-1:0]  busB;
        logic [RADDR_W_DEF-1:0] Rw;
        ex_mem_ctrl_t           ctrl;
    } ex_mem_payload_t;

    // Occupancy encoding {main_v, skid_v}
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    function automatic int payload_w(input int data_w, input int raddr_w);
        return 2 * data_w + raddr_w + CTRL_W;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: main register drives the output, skid catches the beat
// accepted while the consumer stalls. Updates on the falling clock edge.
module pipe_skid_buf
    import ex_mem_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_v;
    logic             skid_v;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic [1:0]       state;

    assign state     = {main_v, skid_v};
    // Ready comes straight from a flop, so no combinational path from out_ready.
    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= '0;
            skid_d <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        main_d <= in_data;
                        main_v <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (out_ready) begin
                        if (in_valid) main_d <= in_data;
                        else          main_v <= 1'b0;
                    end else if (in_valid) begin
                        skid_d <= in_data;
                        skid_v <= 1'b1;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so the input is ignored
                    if (out_ready) begin
                        main_d <= skid_d;
                        skid_v <= 1'b0;
                    end
                end
                default: begin
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_stage_skid.sv
// EX->MEM pipeline stage: skid-buffered payload, side-effect-free bubbles and a saturating
// stall counter. Define EX_MEM_FWD_EN to add the forwarding taps (fwd_valid/Rw/data/load).
module ex_mem_stage_skid
    import ex_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  result_in,
    input  logic [DATA_W-1:0]  busB_in,
    input  logic [RADDR_W-1:0] Rw_in,
    input  logic               MemtoReg_in,
    input  logic               RegWr_in,
    input  logic               MemWr_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result_out,
    output logic [DATA_W-1:0]  busB_out,
    output logic [RADDR_W-1:0] Rw_out,
    output logic               MemtoReg_out,
    output logic               RegWr_out,
    output logic               MemWr_out,
`ifdef EX_MEM_FWD_EN
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_Rw,
    output logic [DATA_W-1:0]  fwd_data,
    output logic               fwd_load,
`endif
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int PW = payload_w(DATA_W, RADDR_W);
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    ex_mem_ctrl_t  ctrl_in;
    ex_mem_ctrl_t  ctrl_q;
    logic [PW-1:0] pay_in;
    logic [PW-1:0] pay_q;

    assign ctrl_in = '{MemtoReg: MemtoReg_in, RegWr: RegWr_in, MemWr: MemWr_in};
    assign pay_in  = {result_in, busB_in, Rw_in, ctrl_in};

    pipe_skid_buf #(.WIDTH(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_q)
    );

    assign {result_out, busB_out, Rw_out, ctrl_q} = pay_q;
    assign MemtoReg_out = ctrl_q.MemtoReg;
    // Write enables are masked so an empty stage can never write regfile or memory.
    assign RegWr_out    = out_valid & ctrl_q.RegWr;
    assign MemWr_out    = out_valid & ctrl_q.MemWr;

    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != STALL_MAX)
            stall_cnt <= stall_cnt + 1'b1;
    end

`ifdef EX_MEM_FWD_EN
    // Writes to r0 are architecturally discarded, so they never forward.
    assign fwd_valid = RegWr_out && (Rw_out != '0);
    assign fwd_Rw    = Rw_out;
    assign fwd_data  = result_out;
    assign fwd_load  = fwd_valid && MemtoReg_out;
`endif

endmodule

// File: tb/tb_ex_mem_stage_skid.sv
// Bench for ex_mem_stage_skid: directed scenarios plus a randomized run checked against a
// queue-based model of a 2-deep in-order buffer with flush and a saturating stall count.
module tb_ex_mem_stage_skid;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int SW = 4;
    localparam int SMAX = (1 << SW) - 1;

    typedef struct packed {
        logic [DW-1:0] result;
        logic [DW-1:0] busB;
        logic [RW-1:0] rw;
        logic          m2r;
        logic          regwr;
        logic          memwr;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] result_in, busB_in, result_out, busB_out;
    logic [RW-1:0] Rw_in, Rw_out;
    logic          MemtoReg_in, RegWr_in, MemWr_in;
    logic          MemtoReg_out, RegWr_out, MemWr_out;
    logic [SW-1:0] stall_cnt;
`ifdef EX_MEM_FWD_EN
    logic          fwd_valid, fwd_load;
    logic [RW-1:0] fwd_Rw;
    logic [DW-1:0] fwd_data;
`endif

    int    checks = 0;
    int    errors = 0;
    beat_t mq[$];
    beat_t sink[$];
    beat_t last_head;
    int    m_cnt;

    always #5 clk = ~clk;

    ex_mem_stage_skid #(.DATA_W(DW), .RADDR_W(RW), .STALL_W(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .result_in    (result_in),
        .busB_in      (busB_in),
        .Rw_in        (Rw_in),
        .MemtoReg_in  (MemtoReg_in),
        .RegWr_in     (RegWr_in),
        .MemWr_in     (MemWr_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result_out   (result_out),
        .busB_out     (busB_out),
        .Rw_out       (Rw_out),
        .MemtoReg_out (MemtoReg_out),
        .RegWr_out    (RegWr_out),
        .MemWr_out    (MemWr_out),
`ifdef EX_MEM_FWD_EN
        .fwd_valid    (fwd_valid),
        .fwd_Rw       (fwd_Rw),
        .fwd_data     (fwd_data),
        .fwd_load     (fwd_load),
`endif
        .stall_cnt    (stall_cnt)
    );

    function automatic beat_t rand_beat();
        beat_t b;
        b.result = $urandom;
        b.busB   = $urandom;
        b.rw     = RW'($urandom);
        b.m2r    = 1'($urandom);
        b.regwr  = 1'($urandom);
        b.memwr  = 1'($urandom);
        return b;
    endfunction

    function automatic beat_t mk_beat(input logic [DW-1:0] r, input logic [RW-1:0] w,
                                      input logic m2r, input logic rwr, input logic mwr);
        beat_t b;
        b.result = r;
        b.busB   = ~r;
        b.rw     = w;
        b.m2r    = m2r;
        b.regwr  = rwr;
        b.memwr  = mwr;
        return b;
    endfunction

    task automatic drive(input beat_t b, input logic v);
        in_valid    = v;
        result_in   = b.result;
        busB_in     = b.busB;
        Rw_in       = b.rw;
        MemtoReg_in = b.m2r;
        RegWr_in    = b.regwr;
        MemWr_in    = b.memwr;
    endtask

    // Reference: in-order queue of capacity 2, pop-then-push, flush empties it.
    task automatic model_edge();
        bit    nonempty;
        bit    acc_in;
        beat_t ib;
        nonempty = (mq.size() > 0);
        if (nonempty && !out_ready && m_cnt < SMAX) m_cnt++;
        if (flush) begin
            mq.delete();
        end else begin
            acc_in = in_valid && (mq.size() < 2);
            ib = '{result: result_in, busB: busB_in, rw: Rw_in,
                   m2r: MemtoReg_in, regwr: RegWr_in, memwr: MemWr_in};
            if (nonempty && out_ready) void'(mq.pop_front());
            if (acc_in) mq.push_back(ib);
        end
        if (mq.size() > 0) last_head = mq[0];
    endtask

    task automatic cycle();
        if (out_valid && out_ready)
            sink.push_back('{result: result_out, busB: busB_out, rw: Rw_out,
                             m2r: MemtoReg_out, regwr: RegWr_out, memwr: MemWr_out});
        @(negedge clk);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        flush     = 1'b0;
        out_ready = 1'b0;
        drive('0, 1'b0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        mq.delete();
        sink.delete();
        last_head = '0;
        m_cnt     = 0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(mk_beat(32'h55, 5'd7, 1'b1, 1'b1, 1'b1), 1'b1);
        cycle();
        drive('0, 1'b0);
        cycle();
        cycle();
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result_out !== '0 || busB_out !== '0 || Rw_out !== '0 ||
            MemtoReg_out !== 1'b0 || RegWr_out !== 1'b0 || MemWr_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b res=%h busB=%h rw=%h m2r=%b rwr=%b mwr=%b want all 0",
                     out_valid, result_out, busB_out, Rw_out, MemtoReg_out, RegWr_out, MemWr_out);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (stall_cnt !== '0) begin
            errors++;
            $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
        #1;
        rst = 1'b0;
        mq.delete();
        last_head = '0;
        m_cnt     = 0;
    endtask

    task automatic test_streaming();
        logic [DW-1:0] exp_r;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_r = 32'h10 * (i + 1);
            drive(mk_beat(exp_r, 5'(i + 1), 1'b0, 1'b1, 1'b0), 1'b1);
            cycle();
            checks++;
            if (out_valid !== 1'b1 || result_out !== exp_r || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_beat%0d: got v=%b res=%h rdy=%b want v=1 res=%h rdy=1",
                         i, out_valid, result_out, in_ready, exp_r);
            end
        end
        drive('0, 1'b0);
        cycle();
        checks++;
        if (out_valid !== 1'b0 || RegWr_out !== 1'b0 || result_out !== 32'h30) begin
            errors++;
            $display("FAIL stream_drain: got v=%b rwr=%b res=%h want v=0 rwr=0 res=30",
                     out_valid, RegWr_out, result_out);
        end
    endtask

    task automatic test_backpressure();
        beat_t src[$];
        beat_t exp_q[$];
        bit    acc;
        int    cyc;
        do_reset();
        src.push_back(mk_beat(32'hA0, 5'd1, 1'b0, 1'b1, 1'b0));
        src.push_back(mk_beat(32'hB0, 5'd2, 1'b0, 1'b1, 1'b0));
        src.push_back(mk_beat(32'hC0, 5'd3, 1'b0, 1'b1, 1'b0));
        exp_q = src;
        cyc = 0;
        while ((src.size() > 0 || out_valid) && cyc < 30) begin
            if (cyc == 3) begin
                checks++;
                if (in_ready !== 1'b0 || result_out !== 32'hA0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_full: got rdy=%b v=%b res=%h want rdy=0 v=1 res=a0",
                             in_ready, out_valid, result_out);
                end
            end
            out_ready = (cyc >= 3);
            if (src.size() > 0) drive(src[0], 1'b1);
            else                drive('0, 1'b0);
            acc = in_valid && in_ready;
            cycle();
            if (acc) void'(src.pop_front());
            cyc++;
        end
        checks++;
        if (cyc >= 30) begin
            errors++;
            $display("FAIL bp_timeout: got %0d cycles want < 30", cyc);
        end
        checks++;
        if (sink.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d beats want 3", sink.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (sink[i].result !== exp_q[i].result || sink[i].rw !== exp_q[i].rw) begin
                    errors++;
                    $display("FAIL bp_order%0d: got res=%h rw=%0d want res=%h rw=%0d",
                             i, sink[i].result, sink[i].rw, exp_q[i].result, exp_q[i].rw);
                end
            end
        end
        checks++;
        if (stall_cnt !== SW'(2) || int'(stall_cnt) != m_cnt) begin
            errors++;
            $display("FAIL bp_stall_cnt: got %0d want 2 (model %0d)", stall_cnt, m_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(mk_beat(32'h1111, 5'd4, 1'b0, 1'b1, 1'b1), 1'b1);
        cycle();
        drive(mk_beat(32'h2222, 5'd5, 1'b0, 1'b1, 1'b1), 1'b1);
        cycle();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_pre_full: got rdy=%b want 0", in_ready);
        end
        drive(mk_beat(32'h3333, 5'd6, 1'b0, 1'b1, 1'b1), 1'b1);
        flush     = 1'b1;
        out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        drive('0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || RegWr_out !== 1'b0 || MemWr_out !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty: got v=%b rwr=%b mwr=%b rdy=%b want v=0 rwr=0 mwr=0 rdy=1",
                     out_valid, RegWr_out, MemWr_out, in_ready);
        end
        checks++;
        if (stall_cnt !== SW'(1) || result_out !== 32'h1111) begin
            errors++;
            $display("FAIL flush_hold: got cnt=%0d res=%h want cnt=1 res=1111", stall_cnt, result_out);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_dropped: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        drive(mk_beat(32'h77, 5'd9, 1'b0, 1'b1, 1'b0), 1'b1);
        cycle();
        drive('0, 1'b0);
        out_ready = 1'b0;
        repeat (20) cycle();
        checks++;
        if (stall_cnt !== SW'(SMAX) || out_valid !== 1'b1 || result_out !== 32'h77) begin
            errors++;
            $display("FAIL saturation: got cnt=%0d v=%b res=%h want cnt=%0d v=1 res=77",
                     stall_cnt, out_valid, result_out, SMAX);
        end
    endtask

    task automatic test_random();
        beat_t exp_b;
        bit    exp_v;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive(rand_beat(), ($urandom_range(0, 9) < 7));
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
            exp_v = (mq.size() > 0);
            exp_b = exp_v ? mq[0] : last_head;
            checks++;
            if (out_valid !== exp_v || in_ready !== (mq.size() < 2) || int'(stall_cnt) != m_cnt ||
                result_out !== exp_b.result || busB_out !== exp_b.busB || Rw_out !== exp_b.rw ||
                MemtoReg_out !== exp_b.m2r || RegWr_out !== (exp_v & exp_b.regwr) ||
                MemWr_out !== (exp_v & exp_b.memwr)) begin
                errors++;
                $display("FAIL random_cyc%0d: got v=%b rdy=%b cnt=%0d res=%h rw=%0d rwr=%b mwr=%b want v=%b rdy=%b cnt=%0d res=%h rw=%0d rwr=%b mwr=%b",
                         n, out_valid, in_ready, stall_cnt, result_out, Rw_out, RegWr_out, MemWr_out,
                         exp_v, (mq.size() < 2), m_cnt, exp_b.result, exp_b.rw,
                         exp_v & exp_b.regwr, exp_v & exp_b.memwr);
            end
        end
        flush = 1'b0;
    endtask

`ifdef EX_MEM_FWD_EN
    task automatic test_fwd();
        do_reset();
        out_ready = 1'b1;
        drive(mk_beat(32'hDEAD, 5'd3, 1'b1, 1'b1, 1'b0), 1'b1);
        cycle();
        checks++;
        if (fwd_valid !== 1'b1 || fwd_load !== 1'b1 || fwd_Rw !== 5'd3 || fwd_data !== 32'hDEAD) begin
            errors++;
            $display("FAIL fwd_load: got fv=%b fl=%b rw=%0d d=%h want fv=1 fl=1 rw=3 d=dead",
                     fwd_valid, fwd_load, fwd_Rw, fwd_data);
        end
        drive(mk_beat(32'hBEEF, 5'd0, 1'b0, 1'b1, 1'b0), 1'b1);
        cycle();
        checks++;
        if (fwd_valid !== 1'b0 || fwd_load !== 1'b0) begin
            errors++;
            $display("FAIL fwd_r0: got fv=%b fl=%b want 0 0", fwd_valid, fwd_load);
        end
        drive('0, 1'b0);
    endtask
`endif

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive('0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
`ifdef EX_MEM_FWD_EN
        test_fwd();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
